// File: rtl/arm_mc_controller.sv
// Multi-cycle ARM controller: fetch/decode/execute FSM driving datapath enables
// and mux selects, with condition evaluation, flag register and memory timeout.
module arm_mc_controller #(
  parameter int ALUCTL_W    = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [19:0]         Instr,
  input  logic [3:0]          ALUFlags,
  input  logic                MemReady,
  output logic                MemReq,
  output logic                MemWrite,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ImmSrc,
  output logic [1:0]          RegSrc,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                Fault,
  output logic [3:0]          State
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5, S_EXECR  = 4'd6, S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9, S_FAULT  = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q;

  // Instr holds bits [31:12]; index = architectural bit - 12.
  logic [3:0] cond_s, cmd_s;
  logic [1:0] op_s;
  logic       ibit_s, ubit_s, sbit_s, pass_s, instr_unused;

  assign cond_s       = Instr[19:16];
  assign op_s         = Instr[15:14];
  assign ibit_s       = Instr[13];
  assign cmd_s        = Instr[12:9];
  assign ubit_s       = Instr[11];
  assign sbit_s       = Instr[8];
  assign instr_unused = ^Instr[7:0];

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cf && !z;
      4'b1001: cond_pass = !cf || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_dec(input logic [3:0] c);
    case (c)
      4'b0100: alu_dec = 3'd0;
      4'b0010: alu_dec = 3'd1;
      4'b0000: alu_dec = 3'd2;
      4'b1100: alu_dec = 3'd3;
      4'b1010: alu_dec = 3'd1;
      4'b0001: alu_dec = 3'd4;
      4'b1101: alu_dec = 3'd5;
      default: alu_dec = 3'd0;
    endcase
  endfunction

  function automatic logic cmd_ok(input logic [3:0] c);
    case (c)
      4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010: cmd_ok = 1'b1;
      4'b0001, 4'b1101:                            cmd_ok = (ALUCTL_W >= 3);
      default:                                     cmd_ok = 1'b0;
    endcase
  endfunction

  assign pass_s = cond_pass(cond_s, flags_q);
  assign State  = state_q;
  assign Fault  = (state_q == S_FAULT);

  // Output decode, next-state, flag update and memory wait counter.
  always_comb begin
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = ALUCTL_W'(0);
    state_d    = state_q;
    flags_d    = flags_q;
    cnt_d      = '0;
    case (state_q)
      S_FETCH: begin
        // active_q holds off the first request until the first edge after reset.
        if (active_q) begin
          MemReq = 1'b1;
          if (MemReady) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            state_d   = S_DECODE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        case (op_s)
          2'b00: begin
            if (!cmd_ok(cmd_s)) begin
              state_d = S_FAULT;
            end else if (ibit_s) begin
              state_d = S_EXECI;
            end else begin
              state_d = S_EXECR;
            end
          end
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b01;
        ALUControl = ubit_s ? ALUCTL_W'(0) : ALUCTL_W'(1);
        state_d    = sbit_s ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemReq  = 1'b1;
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = pass_s;
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        RegSrc   = 2'b10;
        MemWrite = pass_s;
        state_d  = MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = ALUCTL_W'(alu_dec(cmd_s));
        state_d    = S_ALUWB;
        if (sbit_s && pass_s) begin
          flags_d[3:2] = ALUFlags[3:2];
          // Carry and overflow only carry meaning for ADD/SUB/CMP.
          if ((ALUControl == ALUCTL_W'(0)) || (ALUControl == ALUCTL_W'(1))) begin
            flags_d[1:0] = ALUFlags[1:0];
          end else begin
            flags_d[1:0] = flags_q[1:0];
          end
        end else begin
          flags_d = flags_q;
        end
      end
      S_ALUWB: begin
        RegWrite = pass_s && (cmd_s != 4'b1010);
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ImmSrc    = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = pass_s;
        state_d   = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
    if (MemReq && !MemReady) begin
      if (cnt_q == CNT_LIMIT) begin
        state_d = S_FAULT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State, flag, counter and start-up registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      flags_q  <= 4'b0000;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: a cycle table run on two parameterisations
// (ALUCTL_W=2/MEM_TIMEOUT=4 and ALUCTL_W=3/MEM_TIMEOUT=16), plus reset/timeout/EOR sequences.
module tb_arm_mc_controller;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] instr = 20'h0;
  logic        rdy = 1'b0;
  logic [3:0]  flg = 4'b0000;

  logic a_memreq, a_memwrite, a_adrsrc, a_irwrite, a_pcwrite, a_regwrite, a_fault;
  logic [1:0] a_res, a_asa, a_asb, a_imm, a_rsrc, a_alu;
  logic [3:0] a_state;
  logic b_memreq, b_memwrite, b_adrsrc, b_irwrite, b_pcwrite, b_regwrite, b_fault;
  logic [1:0] b_res, b_asa, b_asb, b_imm, b_rsrc;
  logic [2:0] b_alu;
  logic [3:0] b_state;

  arm_mc_controller #(.ALUCTL_W(2), .MEM_TIMEOUT(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .Instr(instr), .ALUFlags(flg), .MemReady(rdy),
    .MemReq(a_memreq), .MemWrite(a_memwrite), .AdrSrc(a_adrsrc), .IRWrite(a_irwrite),
    .PCWrite(a_pcwrite), .RegWrite(a_regwrite), .ResultSrc(a_res), .ALUSrcA(a_asa),
    .ALUSrcB(a_asb), .ImmSrc(a_imm), .RegSrc(a_rsrc), .ALUControl(a_alu),
    .Fault(a_fault), .State(a_state));

  arm_mc_controller #(.ALUCTL_W(3), .MEM_TIMEOUT(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .Instr(instr), .ALUFlags(flg), .MemReady(rdy),
    .MemReq(b_memreq), .MemWrite(b_memwrite), .AdrSrc(b_adrsrc), .IRWrite(b_irwrite),
    .PCWrite(b_pcwrite), .RegWrite(b_regwrite), .ResultSrc(b_res), .ALUSrcA(b_asa),
    .ALUSrcB(b_asb), .ImmSrc(b_imm), .RegSrc(b_rsrc), .ALUControl(b_alu),
    .Fault(b_fault), .State(b_state));

  always #5 clk = ~clk;

  logic [23:0] obs_a, obs_b;
  assign obs_a = {a_memreq, a_memwrite, a_adrsrc, a_irwrite, a_pcwrite, a_regwrite,
                  a_res, a_asa, a_asb, a_imm, a_rsrc, {1'b0, a_alu}, a_fault, a_state};
  assign obs_b = {b_memreq, b_memwrite, b_adrsrc, b_irwrite, b_pcwrite, b_regwrite,
                  b_res, b_asa, b_asb, b_imm, b_rsrc, b_alu, b_fault, b_state};

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [19:0] instr;
    logic        rdy;
    logic [3:0]  flg;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[$];

  localparam logic [19:0] I_ADD   = 20'hE0821;
  localparam logic [19:0] I_SUBS  = 20'hE0511;
  localparam logic [19:0] I_BEQ   = 20'h0A000;
  localparam logic [19:0] I_STRNE = 20'h15021;
  localparam logic [19:0] I_LDR   = 20'hE5921;
  localparam logic [19:0] I_STR   = 20'hE5021;
  localparam logic [19:0] I_EOR   = 20'hE0221;
  localparam logic [3:0]  FX      = 4'b1111;

  // ctl = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}
  function automatic logic [23:0] ex(input logic [3:0] st, input logic [5:0] ctl,
      input logic [1:0] res, input logic [1:0] asa, input logic [1:0] asb,
      input logic [1:0] imm, input logic [1:0] rsrc, input logic [2:0] alu, input logic flt);
    return {ctl, res, asa, asb, imm, rsrc, alu, flt, st};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic addv(input logic [19:0] i, input logic r, input logic [3:0] f, input logic [23:0] e);
    vec_t v;
    v.instr = i; v.rdy = r; v.flg = f; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [19:0] i, input logic r);
    @(negedge clk);
    instr = i; rdy = r; flg = FX;
    #1;
  endtask

  logic [23:0] e_fstall, e_fetch, e_decode, e_ex_add, e_ex_sub, e_aluwb, e_br_t, e_br_n;
  logic [23:0] e_madr_add, e_madr_sub, e_memrd, e_memwb, e_memwr_nw, e_memwr_w, e_fault;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    e_fstall   = ex(4'd0,  6'b100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1'b0);
    e_fetch    = ex(4'd0,  6'b100110, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 3'd0, 1'b0);
    e_decode   = ex(4'd1,  6'b000000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 3'd0, 1'b0);
    e_ex_add   = ex(4'd6,  6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1'b0);
    e_ex_sub   = ex(4'd6,  6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd1, 1'b0);
    e_aluwb    = ex(4'd8,  6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1'b0);
    e_br_t     = ex(4'd9,  6'b000010, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 3'd0, 1'b0);
    e_br_n     = ex(4'd9,  6'b000000, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 3'd0, 1'b0);
    e_madr_add = ex(4'd2,  6'b000000, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 3'd0, 1'b0);
    e_madr_sub = ex(4'd2,  6'b000000, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 3'd1, 1'b0);
    e_memrd    = ex(4'd3,  6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1'b0);
    e_memwb    = ex(4'd4,  6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1'b0);
    e_memwr_nw = ex(4'd5,  6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 3'd0, 1'b0);
    e_memwr_w  = ex(4'd5,  6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 3'd0, 1'b0);
    e_fault    = ex(4'd10, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1'b1);

    // ADD R1,R2,R3 with one fetch stall; S=0 so EXECR flags are not captured
    addv(I_ADD, 1'b0, FX, e_fstall);  addv(I_ADD, 1'b1, FX, e_fetch);
    addv(I_ADD, 1'b1, FX, e_decode);  addv(I_ADD, 1'b1, FX, e_ex_add);
    addv(I_ADD, 1'b1, FX, e_aluwb);
    // SUBS giving zero -> Z=1, then BEQ taken
    addv(I_SUBS, 1'b1, FX, e_fetch);  addv(I_SUBS, 1'b1, FX, e_decode);
    addv(I_SUBS, 1'b1, 4'b0100, e_ex_sub); addv(I_SUBS, 1'b1, FX, e_aluwb);
    addv(I_BEQ, 1'b1, FX, e_fetch);   addv(I_BEQ, 1'b1, FX, e_decode);
    addv(I_BEQ, 1'b1, FX, e_br_t);
    // STRNE while Z=1: request issued, write strobe suppressed
    addv(I_STRNE, 1'b1, FX, e_fetch); addv(I_STRNE, 1'b1, FX, e_decode);
    addv(I_STRNE, 1'b1, FX, e_madr_sub);
    addv(I_STRNE, 1'b0, FX, e_memwr_nw); addv(I_STRNE, 1'b1, FX, e_memwr_nw);
    // SUBS non-zero -> Z=0, BEQ not taken
    addv(I_SUBS, 1'b1, FX, e_fetch);  addv(I_SUBS, 1'b1, FX, e_decode);
    addv(I_SUBS, 1'b1, 4'b0000, e_ex_sub); addv(I_SUBS, 1'b1, FX, e_aluwb);
    addv(I_BEQ, 1'b1, FX, e_fetch);   addv(I_BEQ, 1'b1, FX, e_decode);
    addv(I_BEQ, 1'b1, FX, e_br_n);
    // LDR, MemReady on the 4th MEMRD cycle (exactly at the 4-cycle limit on dut_a)
    addv(I_LDR, 1'b1, FX, e_fetch);   addv(I_LDR, 1'b1, FX, e_decode);
    addv(I_LDR, 1'b1, FX, e_madr_add);
    addv(I_LDR, 1'b0, FX, e_memrd);   addv(I_LDR, 1'b0, FX, e_memrd);
    addv(I_LDR, 1'b0, FX, e_memrd);   addv(I_LDR, 1'b1, FX, e_memrd);
    addv(I_LDR, 1'b1, FX, e_memwb);
    // STR AL: write strobe asserted
    addv(I_STR, 1'b1, FX, e_fetch);   addv(I_STR, 1'b1, FX, e_decode);
    addv(I_STR, 1'b1, FX, e_madr_sub); addv(I_STR, 1'b1, FX, e_memwr_w);

    // Reset state
    #2;
    chk("reset_a", obs_a, 24'h0);
    chk("reset_b", obs_b, 24'h0);
    @(negedge clk);
    chk("reset_hold_a", obs_a, 24'h0);
    reset_n = 1'b1;
    #1;
    chk("release_no_req_a", a_memreq, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      instr = vecs[i].instr; rdy = vecs[i].rdy; flg = vecs[i].flg;
      #1;
      chk($sformatf("vec%0d_a", i), obs_a, vecs[i].exp);
      chk($sformatf("vec%0d_b", i), obs_b, vecs[i].exp);
    end

    // cmd 0001: trapped with 2-bit ALUControl, EOR with 3-bit
    step(I_EOR, 1'b1); chk("eor_fetch_a", obs_a, e_fetch); chk("eor_fetch_b", obs_b, e_fetch);
    step(I_EOR, 1'b1); chk("eor_decode_a", obs_a, e_decode); chk("eor_decode_b", obs_b, e_decode);
    step(I_EOR, 1'b1); chk("eor_fault_a", obs_a, e_fault);
    chk("eor_exec_state_b", b_state, 4'd6); chk("eor_alu_b", b_alu, 3'b100);
    step(I_EOR, 1'b1); chk("eor_fault2_a", obs_a, e_fault); chk("eor_aluwb_b", obs_b, e_aluwb);
    step(I_EOR, 1'b1); chk("fault_terminal_a", obs_a, e_fault); chk("eor_done_b", obs_b, e_fetch);

    // Reset clears the fault
    @(negedge clk); reset_n = 1'b0; #1;
    chk("fault_reset_a", obs_a, 24'h0);
    @(negedge clk); reset_n = 1'b1;

    // Fetch timeout on dut_a after 4 unanswered request cycles
    for (int k = 0; k < 4; k++) begin
      step(I_ADD, 1'b0);
      chk($sformatf("to_wait%0d_a", k), obs_a, e_fstall);
    end
    step(I_ADD, 1'b0); chk("to_fault_a", obs_a, e_fault); chk("to_nofault_b", obs_b, e_fstall);
    step(I_ADD, 1'b1); chk("to_sticky_a", obs_a, e_fault);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("to_reset_a", obs_a, 24'h0);
    chk("to_reset_b", obs_b, 24'h0);
    @(negedge clk); reset_n = 1'b1;

    // Reset asserted mid-MEMRD drops MemReq immediately
    step(I_LDR, 1'b1); chk("ab_fetch_a", obs_a, e_fetch);
    step(I_LDR, 1'b1); chk("ab_decode_a", obs_a, e_decode);
    step(I_LDR, 1'b1); chk("ab_madr_a", obs_a, e_madr_add);
    step(I_LDR, 1'b0); chk("ab_memrd_a", obs_a, e_memrd); chk("ab_memrd_b", obs_b, e_memrd);
    #2; reset_n = 1'b0; #1;
    chk("abort_a", obs_a, 24'h0);
    chk("abort_b", obs_b, 24'h0);
    @(negedge clk); reset_n = 1'b1;
    step(I_ADD, 1'b1); chk("restart_a", obs_a, e_fetch); chk("restart_b", obs_b, e_fetch);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
